pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4, SHALL be the sequential PC increment in bytes.
REQ-003 CLOCK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 jf  input  1  jump flag from the branch/jump controller; 1 = unconditional jump (j/jal/jr).
REQ-006 pcsrc  input  32  next-PC selector from the controller; 32'h1 = sequential, any other value = redirect target (byte address).
REQ-007 stall  input  1  downstream not ready; 1 = hold the current instruction.
REQ-008 imem_ready  input  1  instruction memory data valid for the outstanding request.
REQ-009 imem_rdata  input  32  instruction word returned by memory.
REQ-010 imem_req  output  1  fetch request strobe.
REQ-011 imem_addr  output  32  fetch byte address.
REQ-012 pc  output  32  address of the instruction on instruction.
REQ-013 instruction  output  32  fetched instruction word.
REQ-014 instr_valid  output  1  instruction/pc valid for consumption.
REQ-015 link_addr  output  32  pc + PC_STEP, for jal/jalr link writes.
REQ-016 misalign_err  output  1  sticky; set when a redirect target has bits [1:0] != 0.

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD; reset state IDLE.
REQ-018 IDLE: one cycle after RESET_N deasserts, go to REQ with fetch address RESET_VECTOR.
REQ-019 REQ: imem_req=1, imem_addr=fetch address; stay until imem_ready=1.
REQ-020 On imem_ready in REQ with no redirect: capture imem_rdata into instruction, fetch address into pc, set instr_valid=1, go to HOLD.
REQ-021 HOLD with stall=1: instruction, pc, instr_valid SHALL hold; pcsrc/jf ignored.
REQ-022 HOLD with stall=0: compute next address (redirect target if pcsrc!=32'h1, else pc+PC_STEP), clear instr_valid, go to REQ; zero-stall steady-state throughput is one instruction per two cycles plus memory latency.
REQ-023 Redirect is taken only when jf=1 or pcsrc!=32'h1; jf=1 with pcsrc==32'h1 SHALL be treated as sequential.
REQ-024 Misaligned target: misalign_err set, target bits [1:0] forced to 0, fetch proceeds.
REQ-025 Address arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.
REQ-026 imem_addr SHALL remain stable while imem_req=1 and imem_ready=0.
REQ-027 link_addr SHALL always equal pc + PC_STEP (combinational from pc).
REQ-028 imem_ready outside REQ SHALL be ignored.

Reset
REQ-029 RESET_N low SHALL immediately force: state IDLE, pc=RESET_VECTOR, fetch address=RESET_VECTOR, instruction=32'h0, instr_valid=0, imem_req=0, misalign_err=0.
REQ-030 Reset asserted during REQ SHALL abandon the outstanding request; a late imem_ready after release SHALL be ignored until the next REQ.
REQ-031 misalign_err SHALL clear only on reset.

Structure
REQ-032 Shared package SHALL hold the FSM state typedef, PC_SEQ_SENTINEL=32'h1, and the RESET_VECTOR default.
REQ-033 One sub-module, pc_next_calc (combinational next-address/alignment logic), SHALL be instantiated; all else inline.

Verification
REQ-034 Reset release, imem_ready after 1 cycle with rdata 32'h2008_0005 -> imem_addr 0, then pc=0, instruction=32'h2008_0005, instr_valid=1.
REQ-035 Sequential: pc=32'h10, pcsrc=32'h1, stall=0 -> next imem_addr=32'h14; link_addr=32'h14 while pc=32'h10.
REQ-036 Jump: pc=32'h20, jf=1, pcsrc=32'h40 -> next imem_addr=32'h40, misalign_err=0.
REQ-037 Stall: stall=1 for 3 cycles in HOLD with pcsrc=32'h80 -> pc/instruction unchanged, imem_req=0; on release next imem_addr uses pcsrc then present.
REQ-038 Misaligned jr target 32'h42 -> imem_addr=32'h40, misalign_err=1 and stays 1 until RESET_N low.
REQ-039 RESET_N low mid-REQ at imem_addr 32'h14, memory wait 4 cycles -> all outputs at reset values; after release first imem_addr=RESET_VECTOR; pc=32'hFFFF_FFFC sequential wraps to imem_addr 0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // A pcsrc equal to this value selects the sequential next PC.
  localparam logic [31:0] PC_SEQ_SENTINEL      = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_calc.sv
// Combinational next-fetch-address selection with redirect alignment check.
module pc_next_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic [31:0] pc,
  input  logic        jf,
  input  logic [31:0] pcsrc,
  output logic [31:0] seq_addr,
  output logic [31:0] next_addr,
  output logic        misaligned
);

  logic redirect;

  // jf only matters together with a non-sentinel pcsrc; jf with the sentinel stays sequential.
  always_comb begin
    seq_addr   = pc + PC_STEP;
    redirect   = (jf | (pcsrc != PC_SEQ_SENTINEL)) & (pcsrc != PC_SEQ_SENTINEL);
    next_addr  = seq_addr;
    misaligned = 1'b0;
    if (redirect) begin
      next_addr  = word_align(pcsrc);
      misaligned = (pcsrc[1:0] != 2'b00);
    end else begin
      next_addr  = seq_addr;
      misaligned = 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch sequencer: requests a word, holds it for the consumer, then
// advances to the sequential or redirected address.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        jf,
  input  logic [31:0] pcsrc,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] link_addr,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [31:0]  seq_addr;
  logic [31:0]  next_addr;
  logic         misaligned;

  pc_next_calc #(.PC_STEP(PC_STEP)) u_next (
    .pc         (pc_q),
    .jf         (jf),
    .pcsrc      (pcsrc),
    .seq_addr   (seq_addr),
    .next_addr  (next_addr),
    .misaligned (misaligned)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= RESET_VECTOR;
      pc_q         <= RESET_VECTOR;
      instr_q      <= 32'h0000_0000;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  // imem_ready is only looked at in ST_REQ, so a late response after reset is dropped.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        state_d      = ST_REQ;
        fetch_addr_d = RESET_VECTOR;
      end
      ST_REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          pc_d    = fetch_addr_q;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          fetch_addr_d = next_addr;
          err_d        = err_q | misaligned;
          valid_d      = 1'b0;
          state_d      = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req     = (state_q == ST_REQ);
  assign imem_addr    = fetch_addr_q;
  assign pc           = pc_q;
  assign instruction  = instr_q;
  assign instr_valid  = valid_q;
  assign link_addr    = seq_addr;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written reset/wrap
// sequences, then randomized traffic against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] STEP = 32'd4;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        jf = 1'b0;
  logic [31:0] pcsrc = 32'h1;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] link_addr;
  logic        misalign_err;

  pc_fetch_unit #(.RESET_VECTOR(RV), .PC_STEP(STEP)) dut (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .jf           (jf),
    .pcsrc        (pcsrc),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .link_addr    (link_addr),
    .misalign_err (misalign_err)
  );

  always #5 CLOCK = ~CLOCK;

  int n_vec = 0;
  int n_mis = 0;

  // Model: a request is outstanding, or a word is being held, or neither (just out of reset).
  logic        m_req, m_valid, m_err;
  logic [31:0] m_fetch, m_pc, m_instr;

  typedef struct {
    logic        j;
    logic [31:0] ps;
    logic        st;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t tbl [20];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_req   = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_fetch = RV;
    m_pc    = RV;
    m_instr = 32'h0;
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".req"},   {31'b0, imem_req},     {31'b0, m_req});
    cmp({tag, ".addr"},  imem_addr,             m_fetch);
    cmp({tag, ".pc"},    pc,                    m_pc);
    cmp({tag, ".instr"}, instruction,           m_instr);
    cmp({tag, ".valid"}, {31'b0, instr_valid},  {31'b0, m_valid});
    cmp({tag, ".link"},  link_addr,             m_pc + STEP);
    cmp({tag, ".err"},   {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  // Called at a falling edge; drives inputs, advances the model, checks after the next rising edge.
  task automatic cyc(input logic j, input logic [31:0] ps, input logic st,
                     input logic rdy, input logic [31:0] rd, input string tag);
    jf = j; pcsrc = ps; stall = st; imem_ready = rdy; imem_rdata = rd;
    if (!m_req && !m_valid) begin
      m_req   = 1'b1;
      m_fetch = RV;
    end else if (m_req) begin
      if (rdy) begin
        m_instr = rd;
        m_pc    = m_fetch;
        m_valid = 1'b1;
        m_req   = 1'b0;
      end
    end else if (!st) begin
      if (ps != 32'h1) begin
        if ((ps % 32'd4) != 32'd0) m_err = 1'b1;
        m_fetch = ps - (ps % 32'd4);
      end else begin
        m_fetch = m_pc + STEP;
      end
      m_valid = 1'b0;
      m_req   = 1'b1;
    end
    @(posedge CLOCK);
    @(negedge CLOCK);
    check_model(tag);
  endtask

  // Called at a falling edge; reset lands mid-cycle and is checked before any clock edge.
  task automatic do_reset(input string tag);
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    jf = 1'b0; pcsrc = 32'h1; stall = 1'b0; imem_ready = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ps;

    tbl[0]  = '{1'b0, 32'h1,  1'b0, 1'b0, 32'h0,         1'b1, 32'h00, 32'h00, 32'h0,         1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h1,  1'b0, 1'b0, 32'h0,         1'b1, 32'h00, 32'h00, 32'h0,         1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h1,  1'b0, 1'b1, 32'h2008_0005, 1'b0, 32'h00, 32'h00, 32'h2008_0005, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10, 32'h00, 32'h2008_0005, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h1,  1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 32'h10, 32'h10, 32'hAAAA_0001, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 32'h1,  1'b0, 1'b0, 32'h0,         1'b1, 32'h14, 32'h10, 32'hAAAA_0001, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h1,  1'b0, 1'b1, 32'h1111,      1'b0, 32'h14, 32'h14, 32'h1111,      1'b1, 1'b0};
    tbl[7]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,         1'b1, 32'h20, 32'h14, 32'h1111,      1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h1,  1'b0, 1'b1, 32'h2222,      1'b0, 32'h20, 32'h20, 32'h2222,      1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,         1'b1, 32'h40, 32'h20, 32'h2222,      1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h1,  1'b0, 1'b1, 32'h4444,      1'b0, 32'h40, 32'h40, 32'h4444,      1'b1, 1'b0};
    tbl[11] = '{1'b0, 32'h80, 1'b1, 1'b1, 32'hDEAD,      1'b0, 32'h40, 32'h40, 32'h4444,      1'b1, 1'b0};
    tbl[12] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h0,         1'b0, 32'h40, 32'h40, 32'h4444,      1'b1, 1'b0};
    tbl[13] = '{1'b0, 32'h80, 1'b1, 1'b1, 32'hBEEF,      1'b0, 32'h40, 32'h40, 32'h4444,      1'b1, 1'b0};
    tbl[14] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0,         1'b1, 32'h80, 32'h40, 32'h4444,      1'b0, 1'b0};
    tbl[15] = '{1'b0, 32'h1,  1'b0, 1'b1, 32'h8888,      1'b0, 32'h80, 32'h80, 32'h8888,      1'b1, 1'b0};
    tbl[16] = '{1'b1, 32'h42, 1'b0, 1'b0, 32'h0,         1'b1, 32'h40, 32'h80, 32'h8888,      1'b0, 1'b1};
    tbl[17] = '{1'b0, 32'h1,  1'b0, 1'b1, 32'h5555,      1'b0, 32'h40, 32'h40, 32'h5555,      1'b1, 1'b1};
    tbl[18] = '{1'b1, 32'h1,  1'b0, 1'b0, 32'h0,         1'b1, 32'h44, 32'h40, 32'h5555,      1'b0, 1'b1};
    tbl[19] = '{1'b0, 32'h1,  1'b0, 1'b1, 32'h6666,      1'b0, 32'h44, 32'h44, 32'h6666,      1'b1, 1'b1};

    model_reset();
    @(negedge CLOCK);
    @(negedge CLOCK);
    check_model("por");
    RESET_N = 1'b1;

    for (int i = 0; i < 20; i++) begin
      jf = tbl[i].j; pcsrc = tbl[i].ps; stall = tbl[i].st;
      imem_ready = tbl[i].rdy; imem_rdata = tbl[i].rd;
      @(posedge CLOCK);
      @(negedge CLOCK);
      cmp($sformatf("v%0d.req", i),   {31'b0, imem_req},     {31'b0, tbl[i].e_req});
      cmp($sformatf("v%0d.addr", i),  imem_addr,             tbl[i].e_addr);
      cmp($sformatf("v%0d.pc", i),    pc,                    tbl[i].e_pc);
      cmp($sformatf("v%0d.instr", i), instruction,           tbl[i].e_instr);
      cmp($sformatf("v%0d.valid", i), {31'b0, instr_valid},  {31'b0, tbl[i].e_valid});
      cmp($sformatf("v%0d.link", i),  link_addr,             tbl[i].e_pc + STEP);
      cmp($sformatf("v%0d.err", i),   {31'b0, misalign_err}, {31'b0, tbl[i].e_err});
    end

    // Reset abandons an outstanding request at 0x14; a late ready afterwards is dropped.
    do_reset("b.rst0");
    cyc(1'b0, 32'h1,  1'b0, 1'b0, 32'h0,    "b.idle");
    cyc(1'b0, 32'h1,  1'b0, 1'b1, 32'h100,  "b.f0");
    cyc(1'b1, 32'h14, 1'b0, 1'b0, 32'h0,    "b.j14");
    for (int k = 0; k < 4; k++) cyc(1'b0, 32'h1, 1'b0, 1'b0, 32'h0, "b.wait");
    do_reset("b.rst1");
    cyc(1'b0, 32'h1,  1'b0, 1'b1, 32'hBAD0, "b.late");
    cyc(1'b0, 32'h1,  1'b0, 1'b0, 32'h0,    "b.req0");
    cyc(1'b0, 32'h1,  1'b0, 1'b1, 32'h77,   "b.f1");

    // Top-of-memory wrap.
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,  "w.jmp");
    cyc(1'b0, 32'h1,         1'b0, 1'b1, 32'h99, "w.fetch");
    cmp("w.link", link_addr, 32'h0000_0000);
    cyc(1'b0, 32'h1,         1'b0, 1'b0, 32'h0,  "w.seq");
    cmp("w.addr", imem_addr, 32'h0000_0000);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("r.rst");
      end else begin
        r = $urandom;
        case ($urandom_range(0, 3))
          0, 1:    ps = 32'h1;
          2:       ps = {r[31:2], 2'b00};
          default: ps = r;
        endcase
        cyc(1'($urandom_range(0, 1)), ps, ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 1) == 1), $urandom, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
